// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: result-select encodings, load/store funct3 codes
// and the MEM/WB stage state type.
package riscv_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } mem_wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension for byte and halfword loads.
// Only instantiated by mem_wb_stage when MEM_WB_SUBWORD_EN is defined.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        // Odd halfword addresses fall into the halfword selected by addr[1].
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory access over a valid/ready port, then register-file writeback.
// Sub-word loads/stores are enabled by defining MEM_WB_SUBWORD_EN; otherwise all accesses are full words.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_reg_b,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_pc_plus_4,
    input  logic            ex_regwrite,
    input  logic [1:0]      ex_result_src,
    input  logic            ex_memwrite,
    input  logic [2:0]      ex_funct3,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            writeback_control,
    output logic [4:0]      writeback_rd,
    output logic [XLEN-1:0] writeback_data,
    output logic            stall,
    output logic [1:0]      dbg_state
);

    // Memory port handshake: dmem_req and its address/data/strobes/we are held
    // stable from the first ACCESS cycle until the cycle dmem_ready is high; the
    // transfer completes on that edge and dmem_ready is ignored at any other time.

    mem_wb_state_t r_state, w_next_state;

    logic [4:0]      r_rd;
    logic            r_regwrite;
    logic [1:0]      r_result_src;
    logic            r_memwrite;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_load;

    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [3:0]      r_dmem_wstrb;

    logic            w_is_mem;
    logic            w_accept;
    logic            w_complete;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_strb;
    logic [XLEN-1:0] w_load_data;

    assign w_is_mem   = ex_memwrite | (ex_result_src == RES_MEM);
    assign w_accept   = (r_state != ST_ACCESS) && ex_valid;
    assign w_complete = (r_state == ST_ACCESS) && dmem_ready;

`ifdef MEM_WB_SUBWORD_EN
    logic [1:0] r_addr_lo;
    logic [2:0] r_funct3;

    load_extend u_load_extend (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_st_wdata = ex_reg_b;
        w_st_strb  = ex_memwrite ? 4'b1111 : 4'b0000;
        if (ex_memwrite) begin
            case (ex_funct3)
                F3_SB: begin
                    w_st_wdata = {4{ex_reg_b[7:0]}};
                    w_st_strb  = 4'b0001 << ex_alu_result[1:0];
                end
                F3_SH: begin
                    w_st_wdata = {2{ex_reg_b[15:0]}};
                    w_st_strb  = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_lo <= 2'd0;
            r_funct3  <= 3'd0;
        end else if (w_accept) begin
            r_addr_lo <= ex_alu_result[1:0];
            r_funct3  <= ex_funct3;
        end
    end
`else
    // Word-only build: funct3 has no effect on the access.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^ex_funct3;

    assign w_load_data = dmem_rdata;
    assign w_st_wdata  = ex_reg_b;
    assign w_st_strb   = ex_memwrite ? 4'b1111 : 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCESS: if (dmem_ready) w_next_state = ST_WB;
            default: begin
                if (!ex_valid)     w_next_state = ST_IDLE;
                else if (w_is_mem) w_next_state = ST_ACCESS;
                else               w_next_state = ST_WB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd         <= 5'd0;
            r_regwrite   <= 1'b0;
            r_result_src <= RES_ALU;
            r_memwrite   <= 1'b0;
            r_alu        <= '0;
            r_pc4        <= '0;
            r_load       <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= 4'd0;
        end else if (w_accept) begin
            r_rd         <= ex_rd;
            r_regwrite   <= ex_regwrite;
            r_result_src <= ex_result_src;
            r_memwrite   <= ex_memwrite;
            r_alu        <= ex_alu_result;
            r_pc4        <= ex_pc_plus_4;
            if (w_is_mem) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= ex_memwrite;
                r_dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                r_dmem_wdata <= w_st_wdata;
                r_dmem_wstrb <= w_st_strb;
            end
        end else if (w_complete) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_load     <= w_load_data;
        end
    end

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wstrb = r_dmem_wstrb;

    assign stall     = (r_state == ST_ACCESS);
    assign dbg_state = r_state;

    assign writeback_control = (r_state == ST_WB) && r_regwrite && (r_rd != 5'd0) && !r_memwrite;
    assign writeback_rd      = r_rd;

    always_comb begin
        case (r_result_src)
            RES_MEM: writeback_data = r_load;
            RES_PC4: writeback_data = r_pc4;
            default: writeback_data = r_alu;
        endcase
    end

endmodule
